// File: rtl/dmul_sched_if.sv
// dmul_sched_if: requester, multiplier and response signals of the dMUL scheduler.
interface dmul_sched_if #(
    parameter int W    = 8,
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      mul_iA;
    logic [W-1:0]      mul_iB;
    logic              mul_loadA;
    logic              mul_loadB;
    logic              mul_oC;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_data;
    modport slave (
        input  req_valid, req_a, req_b, mul_oC, rsp_ready,
        output req_ready, mul_iA, mul_iB, mul_loadA, mul_loadB, rsp_valid, rsp_id, rsp_data
    );
    modport master (
        output req_valid, req_a, req_b, mul_oC, rsp_ready,
        input  req_ready, mul_iA, mul_iB, mul_loadA, mul_loadB, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/dmul_sched.sv
// dmul_sched: round-robin scheduler sharing one stochastic multiplier among NREQ requesters.
// Define DMUL_SCHED_ROUND_EN to round the scaled ones count instead of truncating it.
module dmul_sched #(
    parameter int W        = 8,
    parameter int NREQ     = 4,
    parameter int WIN_LOG2 = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    dmul_sched_if.slave  bus,
    output logic         busy
);
    localparam int IW = $clog2(NREQ);
    localparam int SH = WIN_LOG2 - W;
`ifdef DMUL_SCHED_ROUND_EN
    localparam logic [WIN_LOG2:0] RND = (WIN_LOG2+1)'((1 << SH) >> 1);
`else
    localparam logic [WIN_LOG2:0] RND = '0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ALIGN, RUN, RESP} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d, id_q, id_d, gnt_idx, cand;
    logic                gnt_found;
    logic [W-1:0]        b_q, b_d, ia_q, ia_d, ib_q, ib_d, data_q, data_d, sat;
    logic                valid_q, valid_d;
    logic [WIN_LOG2-1:0] phase_q, phase_d;
    logic [WIN_LOG2:0]   ones_q, ones_d, ones_fin, scaled;

    // First valid requester at or after the grant pointer wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        ones_fin = ones_q + (WIN_LOG2+1)'(bus.mul_oC);
        scaled   = (ones_fin + RND) >> SH;
        sat      = |scaled[WIN_LOG2:W] ? '1 : scaled[W-1:0];
        phase_d  = phase_q + 1'b1;
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        b_d      = b_q;
        ia_d     = ia_q;
        ib_d     = ib_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ones_d   = ones_q;
        case (state_q)
            IDLE: if (gnt_found) begin
                ia_d    = bus.req_a[int'(gnt_idx)*W +: W];
                ib_d    = bus.req_a[int'(gnt_idx)*W +: W];
                b_d     = bus.req_b[int'(gnt_idx)*W +: W];
                id_d    = gnt_idx;
                ptr_d   = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IW'(1);
                state_d = LOAD_A;
            end
            LOAD_A: begin
                ib_d    = b_q;
                state_d = LOAD_B;
            end
            LOAD_B: state_d = ALIGN;
            ALIGN: if (&phase_q) begin
                ones_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                ones_d = ones_fin;
                if (&phase_q) begin
                    data_d  = sat;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (bus.rsp_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            b_q     <= '0;
            ia_q    <= '0;
            ib_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            phase_q <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            b_q     <= b_d;
            ia_q    <= ia_d;
            ib_q    <= ib_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            phase_q <= phase_d;
            ones_q  <= ones_d;
        end
    end

    // Grant is combinational, so it is also masked while reset is held
    assign bus.req_ready = (rst_n && state_q == IDLE && gnt_found) ? NREQ'(1) << gnt_idx : '0;
    assign bus.mul_iA    = ia_q;
    assign bus.mul_iB    = ib_q;
    assign bus.mul_loadA = state_q == LOAD_A;
    assign bus.mul_loadB = state_q == LOAD_B;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign busy          = state_q != IDLE;
endmodule
